// File: rtl/flow_math_pkg.sv
// flow_math_pkg - shared types and helpers for the flow_math streaming path.
//   prod_w()  : exact width of a signed-sample x unsigned-coefficient product
//   cnt_w()   : width of a per-block saturated-lane counter
//   sat_s()   : clamp a wide signed value into a signed out_w-bit range
//   chk_state_t : block-framing checker states (IDLE, BLOCK)
package flow_math_pkg;

    // Widest intermediate handled by sat_s; callers sign-extend into it.
    localparam int SAT_MAX_W = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        BLOCK = 1'b1
    } chk_state_t;

    function automatic int prod_w(input int data_w, input int mult_w);
        return data_w + mult_w + 1;
    endfunction

    function automatic int cnt_w(input int n, input int blk_len);
        return $clog2(n * blk_len + 1);
    endfunction

    function automatic logic signed [SAT_MAX_W-1:0] sat_s(
        input logic signed [SAT_MAX_W-1:0] value,
        input int                          out_w
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/flow_mult_rs_round_sat.sv
// flow_round_sat - one lane of round-half-up right shift followed by signed
// saturation. Purely combinational.
//   prod  : signed product, PW bits
//   shift : right-shift amount (0 = pass through)
//   res   : signed OUT_W-bit result
//   sat   : 1 when res was clamped
module flow_round_sat
    import flow_math_pkg::*;
#(
    parameter int PW      = 27,
    parameter int SHIFT_W = 4,
    parameter int OUT_W   = 16
) (
    input  logic signed [PW-1:0]    prod,
    input  logic        [SHIFT_W-1:0] shift,
    output logic signed [OUT_W-1:0] res,
    output logic                    sat
);

    // One guard bit so adding the rounding half can never wrap.
    logic signed [PW:0]          prod_ext;
    logic signed [PW:0]          half;
    logic signed [PW:0]          sum;
    logic signed [PW:0]          shifted;
    logic signed [SAT_MAX_W-1:0] wide;
    logic signed [SAT_MAX_W-1:0] clamped;

    always_comb begin
        prod_ext = {prod[PW-1], prod};
        // With shift=0 the half term is zero, so the same path yields r=p.
        half     = (shift == '0) ? '0 : ((PW+1)'(1) << (shift - 1'b1));
        sum      = prod_ext + half;
        shifted  = sum >>> shift;
        wide     = {{(SAT_MAX_W-PW-1){shifted[PW]}}, shifted};
        clamped  = sat_s(wide, OUT_W);
        res      = OUT_W'(clamped);
        sat      = (clamped != wide);
    end

endmodule

// File: rtl/flow_mult_rs.sv
// flow_mult_rs - N-lane streaming multiplier: signed sample x unsigned
// coefficient, per-beat rounding right shift, signed saturation to OUT_W.
// Latency is PIPE enabled clocks; en=0 freezes every register.
// Optional feature macro: FLOW_MULT_SAT_CNT_EN (per-block saturation count).
// Ports:
//   clk, rst (sync, active high), en (global stall)
//   in_valid, in_data[N*DATA_W], in_mult[N*MULT_W], in_shift, in_sob/eob/sof
//   out_valid, out_data[N*OUT_W], out_sob/eob/sof, out_sat[N]
//   out_sat_cnt : saturated lanes in the block, valid with out_eob
//   out_err     : sticky framing error from the entry-side checker
module flow_mult_rs
    import flow_math_pkg::*;
#(
    parameter int N       = 2,
    parameter int DATA_W  = 16,
    parameter int MULT_W  = 10,
    parameter int SHIFT_W = 4,
    parameter int OUT_W   = 16,
    parameter int PIPE    = 4,
    parameter int BLK_LEN = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       in_valid,
    input  logic [N*DATA_W-1:0]        in_data,
    input  logic [N*MULT_W-1:0]        in_mult,
    input  logic [SHIFT_W-1:0]         in_shift,
    input  logic                       in_sob,
    input  logic                       in_eob,
    input  logic                       in_sof,
    output logic                       out_valid,
    output logic [N*OUT_W-1:0]         out_data,
    output logic                       out_sob,
    output logic                       out_eob,
    output logic                       out_sof,
    output logic [N-1:0]               out_sat,
    output logic [cnt_w(N,BLK_LEN)-1:0] out_sat_cnt,
    output logic                       out_err
);

    localparam int PW   = prod_w(DATA_W, MULT_W);
    localparam int CW   = cnt_w(N, BLK_LEN);
    localparam int BCW  = $clog2(BLK_LEN + 1);
    localparam int ST   = PIPE - 1;   // product-carrying stages before the output stage
    localparam logic [BCW-1:0] LAST = BCW'(BLK_LEN - 1);

    // ---------------- entry multiply ----------------
    logic signed [PW-1:0] op_d;
    logic signed [PW-1:0] op_m;
    logic signed [PW-1:0] prod_entry [N];

    always_comb begin
        op_d = '0;
        op_m = '0;
        for (int i = 0; i < N; i++) begin
            op_d = {{(PW-DATA_W){in_data[i*DATA_W+DATA_W-1]}}, in_data[i*DATA_W +: DATA_W]};
            op_m = {{(PW-MULT_W){1'b0}}, in_mult[i*MULT_W +: MULT_W]};
            prod_entry[i] = op_d * op_m;
        end
    end

    // ---------------- pipeline ----------------
    logic [ST-1:0]        vld_pipe_reg;
    logic [2:0]           side_pipe_reg  [ST];   // {sof, eob, sob}, already valid-qualified
    logic [SHIFT_W-1:0]   shift_pipe_reg [ST];
    logic signed [PW-1:0] prod_pipe_reg  [ST][N];

    logic signed [OUT_W-1:0] rs_res [N];
    logic [N-1:0]            rs_sat;

    logic               out_valid_reg;
    logic [N*OUT_W-1:0] out_data_reg;
    logic [2:0]         out_side_reg;
    logic [N-1:0]       out_sat_reg;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            flow_round_sat #(
                .PW      (PW),
                .SHIFT_W (SHIFT_W),
                .OUT_W   (OUT_W)
            ) u_round_sat (
                .prod  (prod_pipe_reg[ST-1][gi]),
                .shift (shift_pipe_reg[ST-1]),
                .res   (rs_res[gi]),
                .sat   (rs_sat[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_reg  <= '0;
            for (int s = 0; s < ST; s++) begin
                side_pipe_reg[s]  <= '0;
                shift_pipe_reg[s] <= '0;
                for (int i = 0; i < N; i++) begin
                    prod_pipe_reg[s][i] <= '0;
                end
            end
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_side_reg  <= '0;
            out_sat_reg   <= '0;
        end else if (en) begin
            vld_pipe_reg[0]   <= in_valid;
            side_pipe_reg[0]  <= {in_sof, in_eob, in_sob} & {3{in_valid}};
            shift_pipe_reg[0] <= in_shift;
            for (int i = 0; i < N; i++) begin
                prod_pipe_reg[0][i] <= prod_entry[i];
            end
            for (int s = 1; s < ST; s++) begin
                vld_pipe_reg[s]   <= vld_pipe_reg[s-1];
                side_pipe_reg[s]  <= side_pipe_reg[s-1];
                shift_pipe_reg[s] <= shift_pipe_reg[s-1];
                for (int i = 0; i < N; i++) begin
                    prod_pipe_reg[s][i] <= prod_pipe_reg[s-1][i];
                end
            end
            out_valid_reg <= vld_pipe_reg[ST-1];
            out_side_reg  <= side_pipe_reg[ST-1];
            out_sat_reg   <= rs_sat & {N{vld_pipe_reg[ST-1]}};
            for (int i = 0; i < N; i++) begin
                out_data_reg[i*OUT_W +: OUT_W] <= rs_res[i];
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_sob   = out_side_reg[0];
    assign out_eob   = out_side_reg[1];
    assign out_sof   = out_side_reg[2];
    assign out_sat   = out_sat_reg;

    // ---------------- framing checker (entry side) ----------------
    chk_state_t     state_reg, state_next;
    logic [BCW-1:0] bc_reg, bc_next;
    logic           err_reg, err_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            bc_reg    <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            bc_reg    <= bc_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        bc_next    = bc_reg;
        err_next   = err_reg;
        if (en && in_valid) begin
            if (in_sof && !in_sob) begin
                err_next = 1'b1;
            end
            case (state_reg)
                IDLE: begin
                    if (in_sob) begin
                        if (in_eob) begin
                            // A single-beat block only makes sense when BLK_LEN=1.
                            state_next = IDLE;
                            bc_next    = '0;
                            if (BLK_LEN != 1) begin
                                err_next = 1'b1;
                            end
                        end else begin
                            state_next = BLOCK;
                            bc_next    = BCW'(1);
                        end
                    end else begin
                        err_next = 1'b1;
                    end
                end
                BLOCK: begin
                    if (in_sob) begin
                        // Unexpected sob: flag it and treat it as a fresh block start.
                        err_next = 1'b1;
                        bc_next  = BCW'(1);
                    end else if (in_eob) begin
                        if (bc_reg != LAST) begin
                            err_next = 1'b1;
                        end
                        state_next = IDLE;
                        bc_next    = '0;
                    end else if (bc_reg >= LAST) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                        bc_next    = '0;
                    end else begin
                        bc_next = bc_reg + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    bc_next    = '0;
                end
            endcase
        end
    end

    assign out_err = err_reg;

    // ---------------- per-block saturation count ----------------
`ifdef FLOW_MULT_SAT_CNT_EN
    logic [CW-1:0] acc_reg;
    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] pop;

    // Counted from the beat about to enter the output stage so the total is
    // ready in the same cycle that out_eob appears.
    always_comb begin
        pop = '0;
        for (int i = 0; i < N; i++) begin
            pop = pop + CW'(rs_sat[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (en && vld_pipe_reg[ST-1]) begin
            if (side_pipe_reg[ST-1][0]) begin
                acc_reg <= pop;
                if (side_pipe_reg[ST-1][1]) begin
                    cnt_reg <= pop;
                end
            end else begin
                acc_reg <= acc_reg + pop;
                if (side_pipe_reg[ST-1][1]) begin
                    cnt_reg <= acc_reg + pop;
                end
            end
        end
    end

    assign out_sat_cnt = cnt_reg;
`else
    assign out_sat_cnt = '0;
`endif

endmodule

// File: tb/tb_flow_mult_rs.sv
// tb_flow_mult_rs - self-checking bench for flow_mult_rs (default parameters).
// A hand-computed vector table plus randomized blocks checked against a
// plain-arithmetic reference model through an expected-beat queue.
module tb_flow_mult_rs;

    localparam int N       = 2;
    localparam int DATA_W  = 16;
    localparam int MULT_W  = 10;
    localparam int SHIFT_W = 4;
    localparam int OUT_W   = 16;
    localparam int PIPE    = 4;
    localparam int BLK_LEN = 32;
    localparam int CW      = $clog2(N*BLK_LEN+1);

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                in_valid;
    logic [N*DATA_W-1:0] in_data;
    logic [N*MULT_W-1:0] in_mult;
    logic [SHIFT_W-1:0]  in_shift;
    logic                in_sob, in_eob, in_sof;
    logic                out_valid;
    logic [N*OUT_W-1:0]  out_data;
    logic                out_sob, out_eob, out_sof;
    logic [N-1:0]        out_sat;
    logic [CW-1:0]       out_sat_cnt;
    logic                out_err;

    flow_mult_rs #(
        .N(N), .DATA_W(DATA_W), .MULT_W(MULT_W), .SHIFT_W(SHIFT_W),
        .OUT_W(OUT_W), .PIPE(PIPE), .BLK_LEN(BLK_LEN)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .in_data(in_data), .in_mult(in_mult), .in_shift(in_shift),
        .in_sob(in_sob), .in_eob(in_eob), .in_sof(in_sof),
        .out_valid(out_valid), .out_data(out_data),
        .out_sob(out_sob), .out_eob(out_eob), .out_sof(out_sof),
        .out_sat(out_sat), .out_sat_cnt(out_sat_cnt), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N*OUT_W-1:0] data;
        logic [N-1:0]       sat;
        logic               sob, eob, sof;
        int                 idx;
    } exp_t;

    typedef struct {
        int d0, m0, d1, m1, s;
        int r0, r1;
        bit sat0, sat1;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   en_edges = 0;
    bit   last_en  = 1'b0;
    bit   last_rst = 1'b0;
    int   blk_sat  = 0;
    logic [63:0] snap, prev_snap;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: exact product, floor((p + 2^(s-1)) / 2^s), then clamp.
    function automatic void ref_lane(input int d, input int m, input int s, output int r, output bit sat);
        longint p, num, den, q, hi, lo;
        p = longint'(d) * longint'(m);
        if (s == 0) begin
            q = p;
        end else begin
            den = longint'(1) << s;
            num = p + den / 2;
            q   = num / den;
            if ((num % den != 0) && (num < 0)) q = q - 1;
        end
        hi  = (longint'(1) << (OUT_W-1)) - 1;
        lo  = -(longint'(1) << (OUT_W-1));
        sat = 1'b0;
        if (q > hi) begin q = hi; sat = 1'b1; end
        else if (q < lo) begin q = lo; sat = 1'b1; end
        r = int'(q);
    endfunction

    always @(posedge clk) begin
        last_rst <= rst;
        last_en  <= en && !rst;
        if (en && !rst) en_edges <= en_edges + 1;
    end

    // Output monitor: one line per mismatching transaction.
    always @(negedge clk) begin
        snap = {18'd0, out_valid, out_data, out_sat, out_sob, out_eob, out_sof, out_err, out_sat_cnt};
        if (last_rst) begin
            check("reset_outputs", snap, 64'd0);
            blk_sat = 0;
        end else if (last_en) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", {63'd0, out_valid}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("data", out_data, mon_e.data);
                    check("sat", out_sat, mon_e.sat);
                    check("sidebands", {out_sof, out_eob, out_sob}, {mon_e.sof, mon_e.eob, mon_e.sob});
                    check("latency", en_edges - mon_e.idx, PIPE - 1);
                    if (mon_e.sob) blk_sat = $countones(mon_e.sat);
                    else           blk_sat = blk_sat + $countones(mon_e.sat);
                    if (mon_e.eob) begin
`ifdef FLOW_MULT_SAT_CNT_EN
                        check("sat_cnt", out_sat_cnt, blk_sat);
`else
                        check("sat_cnt", out_sat_cnt, 0);
`endif
                    end
                end
            end else begin
                check("idle_flags", {out_sob, out_eob, out_sof, out_sat}, 0);
            end
        end else begin
            check("stall_hold", snap, prev_snap);
        end
        prev_snap = snap;
    end

    task automatic send(input logic [N*DATA_W-1:0] dv, input logic [N*MULT_W-1:0] mv,
                        input logic [SHIFT_W-1:0] sv, input bit sob, input bit eob, input bit sof,
                        input int stall, input bit use_tab,
                        input logic [N*OUT_W-1:0] tdata, input logic [N-1:0] tsat);
        exp_t e;
        int   r;
        bit   s;
        in_data = dv; in_mult = mv; in_shift = sv;
        in_sob = sob; in_eob = eob; in_sof = sof; in_valid = 1'b1;
        if (stall > 0) begin
            en = 1'b0;
            repeat (stall) begin @(posedge clk); #1; end
        end
        en = 1'b1;
        @(posedge clk); #1;
        if (use_tab) begin
            e.data = tdata;
            e.sat  = tsat;
        end else begin
            for (int i = 0; i < N; i++) begin
                ref_lane(int'($signed(dv[i*DATA_W +: DATA_W])), int'(mv[i*MULT_W +: MULT_W]),
                         int'(sv), r, s);
                e.data[i*OUT_W +: OUT_W] = OUT_W'(r);
                e.sat[i] = s;
            end
        end
        e.sob = sob; e.eob = eob; e.sof = sof;
        e.idx = en_edges;
        exp_q.push_back(e);
        in_valid = 1'b0; in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
    endtask

    // Idle cycles with junk sidebands: they must be ignored while in_valid=0.
    task automatic idle(input int n);
        en = 1'b1; in_valid = 1'b0;
        in_sob = 1'($urandom); in_eob = 1'($urandom); in_sof = 1'($urandom);
        repeat (n) begin @(posedge clk); #1; end
        in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin idle(1); n++; end
        idle(2);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset(input bit hold_valid);
        rst = 1'b1; en = 1'b1;
        in_valid = hold_valid; in_sob = hold_valid; in_sof = hold_valid;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; in_sob = 1'b0; in_sof = 1'b0;
        exp_q.delete();
    endtask

    task automatic rand_block(input int n_beats, input int sob2_at, input int eob_at,
                              input int sof_bad_at, input int stall_at, input int stall_len,
                              input bit gaps);
        logic [N*DATA_W-1:0] dv;
        logic [N*MULT_W-1:0] mv;
        int st;
        for (int b = 0; b < n_beats; b++) begin
            for (int i = 0; i < N; i++) begin
                dv[i*DATA_W +: DATA_W] = DATA_W'($urandom);
                mv[i*MULT_W +: MULT_W] = MULT_W'($urandom);
                if ($urandom_range(0, 7) == 0) begin
                    dv[i*DATA_W +: DATA_W] = $urandom_range(0, 1) ? 16'h7fff : 16'h8000;
                    mv[i*MULT_W +: MULT_W] = 10'h3ff;
                end
            end
            st = (b == stall_at) ? stall_len : (gaps && $urandom_range(0, 5) == 0 ? 1 : 0);
            send(dv, mv, SHIFT_W'($urandom), (b == 0) || (b == sob2_at), (b == eob_at),
                 (b == 0) || (b == sof_bad_at), st, 1'b0, '0, '0);
            if (gaps && $urandom_range(0, 4) == 0) idle(1);
        end
    endtask

    vec_t tv [8];

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // lane0 (d0*m0), lane1 (d1*m1), shift, expected results and clamps
        tv[0] = '{d0:100,    m0:3,    d1:-5,     m1:7,    s:0,  r0:300,   r1:-35,    sat0:0, sat1:0};
        tv[1] = '{d0:7,      m0:1,    d1:-7,     m1:1,    s:1,  r0:4,     r1:-3,     sat0:0, sat1:0};
        tv[2] = '{d0:-24,    m0:1,    d1:24,     m1:1,    s:4,  r0:-1,    r1:2,      sat0:0, sat1:0};
        tv[3] = '{d0:32767,  m0:1023, d1:-32768, m1:1023, s:0,  r0:32767, r1:-32768, sat0:1, sat1:1};
        tv[4] = '{d0:32767,  m0:1023, d1:-32768, m1:1023, s:15, r0:1023,  r1:-1023,  sat0:0, sat1:0};
        tv[5] = '{d0:1000,   m0:1000, d1:-1000,  m1:1,    s:4,  r0:32767, r1:-62,    sat0:1, sat1:0};
        tv[6] = '{d0:-2,     m0:1,    d1:3,      m1:1,    s:2,  r0:0,     r1:1,      sat0:0, sat1:0};
        tv[7] = '{d0:32767,  m0:2,    d1:-32768, m1:2,    s:1,  r0:32767, r1:-32768, sat0:0, sat1:0};

        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_data = '0; in_mult = '0; in_shift = '0;
        in_sob = 1'b0; in_eob = 1'b0; in_sof = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        check("reset_err", out_err, 0);

        // Table block: 8 hand vectors then zero padding; 3 saturated lanes total.
        for (int b = 0; b < BLK_LEN; b++) begin
            if (b < 8) begin
                send({DATA_W'(tv[b].d1), DATA_W'(tv[b].d0)}, {MULT_W'(tv[b].m1), MULT_W'(tv[b].m0)},
                     SHIFT_W'(tv[b].s), b == 0, 1'b0, b == 0, 0, 1'b1,
                     {OUT_W'(tv[b].r1), OUT_W'(tv[b].r0)}, {tv[b].sat1, tv[b].sat0});
            end else begin
                send('0, '0, '0, 1'b0, b == BLK_LEN-1, 1'b0, 0, 1'b1, '0, '0);
            end
        end
        drain();
`ifdef FLOW_MULT_SAT_CNT_EN
        check("table_sat_cnt", out_sat_cnt, 3);
`else
        check("table_sat_cnt", out_sat_cnt, 0);
`endif
        check("table_err", out_err, 0);

        // Randomized legal blocks, one with a 5-cycle stall at beat 10.
        rand_block(BLK_LEN, -1, BLK_LEN-1, -1, 10, 5, 1'b0);
        for (int k = 0; k < 4; k++) rand_block(BLK_LEN, -1, BLK_LEN-1, -1, -1, 0, 1'b1);
        drain();
        check("legal_err", out_err, 0);

        // Second sob at beat 10; error must stick through a later legal block.
        do_reset(1'b0);
        rand_block(BLK_LEN, 10, BLK_LEN-1, -1, -1, 0, 1'b0);
        drain();
        check("sob2_err", out_err, 1);
        rand_block(BLK_LEN, -1, BLK_LEN-1, -1, -1, 0, 1'b1);
        drain();
        check("sticky_err", out_err, 1);

        // Early eob at beat 20.
        do_reset(1'b0);
        rand_block(21, -1, 20, -1, -1, 0, 1'b0);
        drain();
        check("early_eob_err", out_err, 1);

        // Valid beat in IDLE without sob.
        do_reset(1'b0);
        send(32'h0001_0002, 20'h00003, '0, 1'b0, 1'b0, 1'b0, 0, 1'b0, '0, '0);
        drain();
        check("no_sob_err", out_err, 1);

        // sof on a non-sob beat.
        do_reset(1'b0);
        rand_block(BLK_LEN, -1, BLK_LEN-1, 5, -1, 0, 1'b0);
        drain();
        check("sof_err", out_err, 1);

        // Reset in the middle of a block: in-flight beats must vanish.
        do_reset(1'b0);
        rand_block(12, -1, -1, -1, -1, 0, 1'b0);
        do_reset(1'b1);
        idle(10);
        check("flush_valid", out_valid, 0);
        rand_block(BLK_LEN, -1, BLK_LEN-1, -1, -1, 0, 1'b1);
        drain();
        check("post_reset_err", out_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flow_mult_rs.md
Name: flow_mult_rs

Overview:
- Next-generation N-lane streaming multiplier for the flow_math path: signed sample × unsigned coefficient, per-beat programmable right-shift with round-half-up, signed saturation to OUT_W.
- Carries block/frame sidebands (sob/eob/sof) through a PIPE-deep enable-stalled pipeline.
- Adds a block-framing checker and an optional per-block saturation counter.
- Sits between quantisation-table lookup and entropy-coding stages.

Parameters:
- N, 2, lane count (≥1)
- DATA_W, 16, signed input sample width
- MULT_W, 10, unsigned multiplier width
- SHIFT_W, 4, width of in_shift; shift range 0..2^SHIFT_W-1
- OUT_W, 16, signed output width (≤ DATA_W+MULT_W+1)
- PIPE, 4, latency in enabled cycles (≥2)
- BLK_LEN, 32, beats per block (sob beat through eob beat)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  global pipeline enable; 0 = hold everything
- in_valid  in  1  input beat valid
- in_data  in  N×DATA_W  signed samples, packed lanes
- in_mult  in  N×MULT_W  unsigned multipliers
- in_shift  in  SHIFT_W  right-shift amount, applies to all lanes of the beat
- in_sob / in_eob / in_sof  in  1 each  start-of-block / end-of-block / start-of-frame, qualified by in_valid
- out_valid  out  1  output beat valid
- out_data  out  N×OUT_W  signed results
- out_sob / out_eob / out_sof  out  1 each  delayed sidebands
- out_sat  out  N  per-lane saturation flag for the current output beat
- out_sat_cnt  out  $clog2(N*BLK_LEN+1)  saturated lane count of the block; valid with out_eob
- out_err  out  1  sticky framing error

Behaviour:
- One clock domain. Reset is synchronous, active-high; the reset port is named rst and the clock port clk.
- Reset state: all outputs 0; pipeline valid bits 0; checker FSM in IDLE; counters 0.
- en=1:
  - Pipeline advances one stage per clock.
  - Beat presented at edge k appears on outputs after exactly PIPE enabled edges.
- en=0: all state holds; outputs hold; inputs are ignored, so upstream must hold the beat.
- Sidebands are ANDed with in_valid at entry. out_sob/eob/sof/sat are 0 whenever out_valid=0.
- Arithmetic per lane:
  - p = in_data × in_mult, signed, width DATA_W+MULT_W+1, exact.
  - s = in_shift. If s=0, r=p; else r = (p + 2^(s-1)) >>> s (arithmetic shift, round half toward +inf).
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_sat[i]=1 iff clamped.
- Framing checker FSM, evaluated on valid beats at entry, with beat counter bc:
  - IDLE:
    - sob → BLOCK with bc=1. If eob also set, that is legal only when BLK_LEN=1 (stay IDLE); otherwise err.
    - Valid beat without sob → err, stay IDLE.
  - BLOCK:
    - sob → err; restart the block with bc=1.
    - eob with bc==BLK_LEN-1 → IDLE.
    - eob with bc≠BLK_LEN-1 → err, then IDLE.
    - bc reaching BLK_LEN-1 without eob → err, then IDLE.
    - Otherwise bc++.
  - sof without sob → err.
- out_err is sticky; only rst clears it. The error does not alter the data path; beats still flow.
- Reset mid-block: pipeline is flushed, no outputs are produced for in-flight beats, FSM returns to IDLE.

Optional Feature:
- Macro: FLOW_MULT_SAT_CNT_EN.
- Defined:
  - The accumulator loads popcount(out_sat) on the output sob beat and adds popcount on later valid beats.
  - On the out_eob beat, out_sat_cnt = block total including that beat.
  - out_sat_cnt holds until the next eob beat.
- Undefined: no counter logic; out_sat_cnt tied 0. out_sat remains present.

Decomposition:
- Package flow_math_pkg:
  - product-width and counter-width localparam functions
  - function sat_s(value, OUT_W)
  - checker FSM state enum (IDLE, BLOCK)
- Sub-module flow_round_sat: one lane of round-and-saturate, purely combinational, instantiated N times between pipeline stages.
- Pipeline registers, checker FSM and counter live in the top module.

Test Plan:
- Defaults. Lane0 data=100, mult=3, shift=0 → out_data=300, out_sat=0, exactly 4 enabled cycles later.
- shift=1: data=7, mult=1 → 4. data=-7, mult=1 → -3. shift=4: data=-24, mult=1 → -1 (-1.5 rounds up).
- data=32767, mult=1023, shift=0 → 32767, sat=1. data=-32768, mult=1023 → -32768, sat=1. Full 32-beat block with 3 saturated lanes → out_sat_cnt=3 on the eob beat (macro defined), 0 (macro undefined).
- 32-beat block with en deasserted for 5 cycles mid-block (inputs held) → outputs identical to the en=1 run, shifted by 5 cycles; no duplicated or dropped beats; out_err=0.
- Framing errors:
  - Second sob at beat 10 → out_err=1 and stays 1 through later legal blocks.
  - eob at beat 20 → out_err=1.
  - Valid beat in IDLE without sob → out_err=1.
- rst pulsed 1 cycle at beat 12 of a block → next cycle all outputs 0, no stale beats emerge; a new legal block afterwards yields out_err=0.
